alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation present on alu_ctrl/src_a/src_b.
REQ-005 SHALL have port in_ready  output  1  unit accepts an operation this cycle.
REQ-006 SHALL have port alu_ctrl  input  4  ALUControl code from the ALU decoder.
REQ-007 SHALL have port src_a  input  XLEN  operand A (rs1 or PC).
REQ-008 SHALL have port src_b  input  XLEN  operand B (rs2 or immediate).
REQ-009 SHALL have port out_valid  output  1  result/zero/illegal hold a completed operation.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port result  output  XLEN  registered result.
REQ-012 SHALL have port zero  output  1  result equals zero (branch compare).
REQ-013 SHALL have port illegal  output  1  alu_ctrl was an unassigned code.

Function
REQ-014 SHALL accept an operation on a cycle where in_valid and in_ready are both 1; nothing else latches inputs.
REQ-015 SHALL decode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed, result 0/1), 0110 sltu, 1000 auipc (A+B), 1001 lui (B), 1010 sll, 1011 sra, 1100 srl, 1111 mul (low XLEN bits of A*B).
REQ-016 SHALL take the shift amount from src_b[4:0] only; add/sub/mul SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-017 SHALL produce result 0 with illegal=1 for codes 0111, 1101, 1110; all other codes give illegal=0.
REQ-018 SHALL implement states IDLE, MUL, HOLD: IDLE->HOLD on accepting a non-mul op; IDLE->MUL on accepting mul; MUL->HOLD after XLEN iterations; HOLD->IDLE when out_ready=1, or HOLD->HOLD/MUL on simultaneous out_ready and new accept.
REQ-019 SHALL give single-cycle ops latency 1: accepted in cycle N, out_valid=1 in cycle N+1.
REQ-020 SHALL compute mul with a radix-2 shift-add iteration, one bit per cycle, giving out_valid in cycle N+XLEN+1 (33 at XLEN=32).
REQ-021 SHALL drive in_ready = 1 in IDLE, 0 in MUL, and out_ready in HOLD (back-to-back single-cycle ops at full rate).
REQ-022 SHALL keep result, zero, illegal stable while out_valid=1 and out_ready=0.
REQ-023 SHALL ignore in_valid and input changes while in MUL.

Reset
REQ-024 SHALL, on reset assertion, immediately force state IDLE, out_valid=0, result=0, zero=0, illegal=0, in_ready=0 while reset is high.
REQ-025 SHALL abandon any in-flight mul on reset with no result emitted; first accept is possible the cycle after reset deasserts.

Configuration
REQ-026 SHALL gate the multiplier with macro ALU_EXEC_MUL_EN: defined -> mul per REQ-020; undefined -> code 1111 treated as unassigned per REQ-017 (latency 1, illegal=1), state MUL and the multiplier absent.

Structure
REQ-027 SHALL place the ALUControl code constants (enumerated type), XLEN default and the state enumeration in shared package alu_pkg, also used by ALU_Decoder users.
REQ-028 SHALL place the iterative multiplier in sub-module alu_mul_iter (start, operands, done, product), instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-029 SHALL cover: add A=0x7FFFFFFF, B=1 -> result 0x80000000, zero=0, out_valid one cycle after accept.
REQ-030 SHALL cover: sub A=5, B=5 -> result 0, zero=1; slt A=0xFFFFFFFF, B=1 -> 1; sltu same operands -> 0.
REQ-031 SHALL cover: sra A=0x80000000, B=0x24 -> 0xF8000000 (uses 4); srl same -> 0x08000000; lui B=0x12345000 -> 0x12345000.
REQ-032 SHALL cover: mul A=0xFFFFFFFF, B=3 -> 0xFFFFFFFD at cycle N+33, in_ready=0 throughout; without macro -> result 0, illegal=1 at N+1.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles after result -> outputs stable, in_ready=0; then out_ready=1 with new add accepted same cycle -> new result next cycle.
REQ-034 SHALL cover: reset asserted at mul iteration 10 -> out_valid=0 immediately, no stale product after release; code 1101 -> result 0, illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, default operand width and execute-unit states.
// ALU_EXEC_MUL_EN adds the multiply-in-progress state.
package alu_pkg;

    parameter int unsigned XlenDefault = 32;

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluAnd   = 4'b0010,
        AluOr    = 4'b0011,
        AluXor   = 4'b0100,
        AluSlt   = 4'b0101,
        AluSltu  = 4'b0110,
        AluAuipc = 4'b1000,
        AluLui   = 4'b1001,
        AluSll   = 4'b1010,
        AluSra   = 4'b1011,
        AluSrl   = 4'b1100,
        AluMul   = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
`ifdef ALU_EXEC_MUL_EN
        StMul  = 2'd2,
`endif
        StHold = 2'd1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, XLEN cycles after start.
// done/product are combinational in the final iteration so the caller can register them directly.
module alu_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CntW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] acc_next;
    logic            last_iter;

    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (cnt_q == CntW'(XLEN - 1));
    assign done      = busy_q && last_iter;
    assign product   = acc_next;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Bits shifted out above XLEN are dropped, so the product wraps naturally.
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !last_iter;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Define ALU_EXEC_MUL_EN to include the iterative multiplier; otherwise code 1111 is illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [4:0]      shamt;

    assign shamt = src_b[4:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl_e'(alu_ctrl))
            AluAdd:   alu_res = src_a + src_b;
            AluSub:   alu_res = src_a - src_b;
            AluAnd:   alu_res = src_a & src_b;
            AluOr:    alu_res = src_a | src_b;
            AluXor:   alu_res = src_a ^ src_b;
            AluSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            AluSltu:  alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            AluAuipc: alu_res = src_a + src_b;
            AluLui:   alu_res = src_b;
            AluSll:   alu_res = src_a << shamt;
            AluSra:   alu_res = $signed(src_a) >>> shamt;
            AluSrl:   alu_res = src_a >> shamt;
            // Unassigned codes, and 1111 when the multiplier is built out.
            default:  alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign is_mul = (alu_ctrl == AluMul);

    alu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .op_a    (src_a),
        .op_b    (src_b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Holding a result still admits a new op when the consumer drains it in the same cycle.
    assign in_ready = !reset && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            StIdle, StHold: begin
                if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                    if (is_mul) begin
                        state_d   = StMul;
                        mul_start = 1'b1;
                    end else
`endif
                    begin
                        state_d   = StHold;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                    end
                end
            end
`ifdef ALU_EXEC_MUL_EN
            StMul: begin
                if (mul_done) begin
                    state_d   = StHold;
                    result_d  = mul_product;
                    zero_d    = (mul_product == '0);
                    illegal_d = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = (state_q == StHold);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
